control_sequencer: RTL

Hardwired Moore control unit that sequences the 32-bit bus datapath through instruction fetch and execute. It generates every bus-source select, register load enable, memory strobe, ALU select and Select-and-Encode control per T-step. Its outputs connect directly to the datapath control inputs. IR and the CONFF result come back as status.

---
 rtl/control_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Moore control FSM that steps the bus datapath through fetch (T0-T2) and per-opcode execute (T3-T7).
// One state per T-step; memory steps hold for MEM_WAIT+1 cycles; no upstream handshake, only stop/clr.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [5:0]  ALU_ADD  = 6'd3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic [31:0] i,
  output logic [31:0] reg_enable,
  output logic [3:0]  Gra,
  output logic [3:0]  Grb,
  output logic [3:0]  Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        incPC,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        conIn,
  output logic        outport1Enable,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_BR = 5'd18,
                         OP_JR = 5'd20, OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24,
                         OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [4:0] op;
  logic       is_alu, is_imm, is_md, is_ld, is_ldi, is_st, is_br, is_ill;
  logic       done, enters_wait;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_alu    = (op >= 5'd3) && (op <= 5'd11);
  assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
  assign is_md     = (op == 5'd15) || (op == 5'd16);
  assign is_ld     = (op == OP_LD);
  assign is_ldi    = (op == OP_LDI);
  assign is_st     = (op == OP_ST);
  assign is_br     = (op == OP_BR);
  assign is_ill    = !(is_alu || is_imm || is_md || is_ld || is_ldi || is_st || is_br ||
                       op == OP_JR || op == OP_IN || op == OP_OUT || op == OP_MFHI ||
                       op == OP_MFLO || op == OP_NOP || op == OP_HALT);
  assign done      = (cnt == 3'd0);
  assign run       = (state != S_HALT);

  // The wait counter is reloaded only when a memory step is first entered.
  assign enters_wait = (state_nx != state) &&
                       ((state_nx == S_T1) || (state_nx == S_T6 && is_ld) || (state_nx == S_T7 && is_st));

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_RST;
      cnt        <= 3'd0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nx;
      if (enters_wait)      cnt <= WAIT_LOAD;
      else if (cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == S_T3 && is_ill) illegal_op <= 1'b1;
    end
  end

  always_comb begin
    state_t fin;
    fin      = stop ? S_HALT : S_T0;
    state_nx = state;
    case (state)
      S_RST:  state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = done ? S_T2 : S_T1;
      S_T2:   state_nx = S_T3;
      S_T3: begin
        if (op == OP_HALT) state_nx = S_HALT;
        else if (is_alu || is_imm || is_md || is_ld || is_ldi || is_st || is_br) state_nx = S_T4;
        else state_nx = fin;
      end
      S_T4:   state_nx = S_T5;
      S_T5:   state_nx = (is_md || is_ld || is_st || is_br) ? S_T6 : fin;
      S_T6: begin
        if (is_ld)      state_nx = done ? S_T7 : S_T6;
        else if (is_st) state_nx = S_T7;
        else            state_nx = fin;
      end
      S_T7:   state_nx = (is_st && !done) ? S_T7 : fin;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    i = '0; reg_enable = '0; Gra = 4'd0; Grb = 4'd0; Grc = 4'd0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; incPC = 1'b0; ALU_Sel = '0;
    read = 1'b0; write = 1'b0; conIn = 1'b0; outport1Enable = 1'b0;
    case (state)
      S_T0: begin i[20] = 1'b1; reg_enable[23] = 1'b1; incPC = 1'b1; end
      S_T1: begin read = 1'b1; reg_enable[22] = done; end
      S_T2: begin i[22] = 1'b1; reg_enable[21] = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm)            begin Grb = 4'd1; Rout = 1'b1; reg_enable[24] = 1'b1; end
        else if (is_md)                  begin Gra = 4'd1; Rout = 1'b1; reg_enable[24] = 1'b1; end
        else if (is_ld || is_ldi || is_st) begin Grb = 4'd1; BAout = 1'b1; reg_enable[24] = 1'b1; end
        else if (is_br)                  begin Gra = 4'd1; Rout = 1'b1; conIn = 1'b1; end
        else if (op == OP_JR)            begin Gra = 4'd1; Rout = 1'b1; reg_enable[20] = 1'b1; end
        else if (op == OP_IN)            begin i[25] = 1'b1; Gra = 4'd1; Rin = 1'b1; end
        else if (op == OP_OUT)           begin Gra = 4'd1; Rout = 1'b1; outport1Enable = 1'b1; end
        else if (op == OP_MFHI)          begin i[16] = 1'b1; Gra = 4'd1; Rin = 1'b1; end
        else if (op == OP_MFLO)          begin i[17] = 1'b1; Gra = 4'd1; Rin = 1'b1; end
      end
      S_T4: begin
        if (is_alu)      begin Grc = 4'd1; Rout = 1'b1; ALU_Sel = {1'b0, op}; reg_enable[19] = 1'b1; end
        else if (is_imm) begin i[24] = 1'b1; ALU_Sel = {1'b0, op}; reg_enable[19] = 1'b1; end
        else if (is_md)  begin Grb = 4'd1; Rout = 1'b1; ALU_Sel = {1'b0, op}; reg_enable[19:18] = 2'b11; end
        else if (is_ld || is_ldi || is_st) begin i[24] = 1'b1; ALU_Sel = ALU_ADD; reg_enable[19] = 1'b1; end
        else if (is_br)  begin i[20] = 1'b1; reg_enable[24] = 1'b1; end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin i[19] = 1'b1; Gra = 4'd1; Rin = 1'b1; end
        else if (is_md)         begin i[19] = 1'b1; reg_enable[17] = 1'b1; end
        else if (is_ld || is_st) begin i[19] = 1'b1; reg_enable[23] = 1'b1; end
        else if (is_br)         begin i[24] = 1'b1; ALU_Sel = ALU_ADD; reg_enable[19] = 1'b1; end
      end
      S_T6: begin
        if (is_md)      begin i[18] = 1'b1; reg_enable[16] = 1'b1; end
        else if (is_ld) begin read = 1'b1; reg_enable[22] = done; end
        else if (is_st) begin Gra = 4'd1; Rout = 1'b1; reg_enable[22] = 1'b1; end
        else if (is_br) begin i[19] = 1'b1; reg_enable[20] = con_ff; end
      end
      S_T7: begin
        if (is_ld)      begin i[22] = 1'b1; Gra = 4'd1; Rin = 1'b1; end
        else if (is_st) write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
